// File: rtl/consumer_request_queue.sv
// consumer_request_queue
// Per-consumer request buffer in front of the round-robin scheduling kernel.
// Requests enter through a valid/ready handshake, are held in a DEPTH-entry
// FIFO, and the head is offered to the kernel as one packed word. The kernel
// pops the head with grant. Occupancy and a saturating head-wait counter are
// exported so starvation can be monitored.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   in_valid     consumer offers a request
//   in_ready     queue has room (count < DEPTH)
//   in_addr      request bank address
//   in_value     request data value
//   req          packed head {valid, addr, value}; all zero when empty
//   grant        kernel consumed the presented head this cycle
//   count        current occupancy, 0..DEPTH
//   wait_cycles  cycles the current head has waited without a grant
module consumer_request_queue #(
  parameter int ADDR_WIDTH    = 4,
  parameter int VALUE_WIDTH   = 8,
  parameter int DEPTH         = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int REQ_WIDTH     = ADDR_WIDTH + VALUE_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [VALUE_WIDTH-1:0]       in_value,
  output logic [REQ_WIDTH-1:0]         req,
  input  logic                         grant,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [COUNTER_WIDTH-1:0]     wait_cycles
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = ADDR_WIDTH + VALUE_WIDTH;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               head_valid;
  logic               push;
  logic               pop;

  // Handshake and pop qualifiers. in_ready depends only on registered count,
  // so a grant in the same cycle never opens room for a push into a full queue.
  assign head_valid = (count != '0);
  assign in_ready   = (count < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = grant && head_valid;

  // Head presentation: combinational read of storage at the registered read
  // pointer, zeroed when empty so the kernel sees a clean all-zero word.
  assign req = head_valid ? {1'b1, mem[rd_ptr]} : '0;

  // Storage needs no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_addr, in_value};
    end
  end

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-wait counter: cleared whenever the head is granted so the next head
  // starts from zero; saturates instead of wrapping so a starved consumer stays
  // visibly starved. It can only become nonzero while a head is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cycles <= '0;
    end else if (pop) begin
      wait_cycles <= '0;
    end else if (head_valid && (wait_cycles != '1)) begin
      wait_cycles <= wait_cycles + COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_consumer_request_queue.sv
// tb_consumer_request_queue
// Directed bench for consumer_request_queue with default parameters
// (ADDR_WIDTH=4, VALUE_WIDTH=8, DEPTH=4, COUNTER_WIDTH=8). Inputs change 1 ns
// after a rising edge; outputs are checked at that same point, reflecting the
// state produced by the edge just passed.
module tb_consumer_request_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [7:0]  in_value;
  logic [12:0] req;
  logic        grant;
  logic [2:0]  count;
  logic [7:0]  wait_cycles;

  int checks;
  int errors;

  consumer_request_queue dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_value    (in_value),
    .req         (req),
    .grant       (grant),
    .count       (count),
    .wait_cycles (wait_cycles)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and land 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the consumer inputs for the next edge.
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [7:0] d, input logic g);
    in_valid = v;
    in_addr  = a;
    in_value = d;
    grant    = g;
  endtask

  function automatic logic [12:0] mk_req(input logic [3:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);

    // Reset state
    #3;
    checkOutput("rst_req", 32'(req), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_wait", 32'(wait_cycles), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h1);
    #9 reset = 1'b0;  // released at 12 ns, between edges
    tick();

    // 1: single push, then watch the wait counter climb
    applyStimulus(1'b1, 4'h3, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t1_req", 32'(req), 32'h13A5);
    checkOutput("t1_count", 32'(count), 32'h1);
    checkOutput("t1_wait0", 32'(wait_cycles), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("t1_wait", 32'(wait_cycles), 32'(i));
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t1_req_empty", 32'(req), 32'h0);
    checkOutput("t1_wait_clr", 32'(wait_cycles), 32'h0);

    // 2: fill to DEPTH, refuse a 5th, full+grant does not push, drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i), 8'(8'h10 + i), 1'b0);
      tick();
    end
    checkOutput("t2_count_full", 32'(count), 32'h4);
    checkOutput("t2_ready_full", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 4'hF, 8'hFF, 1'b0);
    tick();
    checkOutput("t2_count_nopush", 32'(count), 32'h4);
    checkOutput("t2_head0", 32'(req), 32'h1010);
    applyStimulus(1'b1, 4'hF, 8'hFF, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t2_full_grant_count", 32'(count), 32'h3);
    for (int i = 1; i < 4; i++) begin
      checkOutput("t2_head", 32'(req), 32'(mk_req(4'(i), 8'(8'h10 + i))));
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t2_req_empty", 32'(req), 32'h0);
    checkOutput("t2_count_empty", 32'(count), 32'h0);

    // 3: two held, then 6 cycles of simultaneous push and pop across the wrap
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'(i), 8'(8'h20 + i), 1'b0);
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      checkOutput("t3_head", 32'(req), 32'(mk_req(4'(j), 8'(8'h20 + j))));
      applyStimulus(1'b1, 4'(j + 2), 8'(8'h22 + j), 1'b1);
      tick();
      checkOutput("t3_count", 32'(count), 32'h2);
      checkOutput("t3_wait", 32'(wait_cycles), 32'h0);
    end
    for (int j = 6; j < 8; j++) begin
      checkOutput("t3_tail", 32'(req), 32'(mk_req(4'(j), 8'(8'h20 + j))));
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t3_count_empty", 32'(count), 32'h0);

    // 4: grant while empty is ignored, next push appears normally
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t4_count", 32'(count), 32'h0);
    checkOutput("t4_req", 32'(req), 32'h0);
    checkOutput("t4_wait", 32'(wait_cycles), 32'h0);
    applyStimulus(1'b1, 4'h9, 8'h5C, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t4_push_req", 32'(req), 32'h195C);
    checkOutput("t4_push_count", 32'(count), 32'h1);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);

    // 5: starve the head for 300 cycles, counter saturates, grant clears it
    applyStimulus(1'b1, 4'h2, 8'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    repeat (254) tick();
    checkOutput("t5_wait_254", 32'(wait_cycles), 32'hFE);
    tick();
    checkOutput("t5_wait_255", 32'(wait_cycles), 32'hFF);
    repeat (45) tick();
    checkOutput("t5_wait_sat", 32'(wait_cycles), 32'hFF);
    checkOutput("t5_head", 32'(req), 32'h1277);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t5_wait_clr", 32'(wait_cycles), 32'h0);
    checkOutput("t5_count", 32'(count), 32'h0);

    // 6: asynchronous reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(4'hA + i), 8'(8'h31 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t6_count_pre", 32'(count), 32'h3);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_count", 32'(count), 32'h0);
    checkOutput("t6_rst_req", 32'(req), 32'h0);
    checkOutput("t6_rst_ready", 32'(in_ready), 32'h1);
    checkOutput("t6_rst_wait", 32'(wait_cycles), 32'h0);
    #2 reset = 1'b0;
    applyStimulus(1'b1, 4'hD, 8'h44, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("t6_post_req", 32'(req), 32'h1D44);
    checkOutput("t6_post_count", 32'(count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/consumer_request_queue.md
Name: consumer_request_queue

Overview:
- Per-consumer request buffer directly upstream of the round-robin scheduling kernel; one instance per consumer.
- Accepts memory requests from a consumer with a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Presents the head entry to the kernel as one packed request word and pops it when the kernel grants it.
- Reports occupancy and a saturating head-wait counter for starvation monitoring.

Parameters:
- ADDR_WIDTH, 4, bank address width.
- VALUE_WIDTH, 8, data value width.
- DEPTH, 4, FIFO entries; any integer >= 2, not required to be a power of two.
- COUNTER_WIDTH, 8, width of wait_cycles.
- REQ_WIDTH, ADDR_WIDTH+VALUE_WIDTH+1, packed request width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  consumer offers a request.
- in_ready  out  1  queue can accept a request this cycle.
- in_addr  in  ADDR_WIDTH  request address.
- in_value  in  VALUE_WIDTH  request value.
- req  out  REQ_WIDTH  packed head request to the kernel: bit REQ_WIDTH-1 = valid, then addr, then value in the LSBs.
- grant  in  1  kernel consumed the presented head this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- wait_cycles  out  COUNTER_WIDTH  cycles the current head has waited without grant.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - Outputs go to req=0, count=0, wait_cycles=0, in_ready=1.
  - Read and write pointers go to 0.
  - Storage contents are don't-care.
  - Reset during operation flushes all entries immediately.
- Push: occurs on a rising edge when in_valid && in_ready. Writes {in_addr, in_value} at the write pointer, which advances.
- in_ready = (count < DEPTH); combinational from registered state only, with no dependence on grant. When full, no push happens even if a grant occurs in the same cycle.
- Pop: occurs on a rising edge when grant && req valid; the read pointer advances. A grant while the queue is empty is ignored, with no state change.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not a power-of-two mask.
- No fall-through: a request pushed at edge N is visible on req after edge N. With the queue empty beforehand, req valid goes to 1 in cycle N+1.
- req:
  - Valid bit = (count != 0).
  - addr/value fields = the entry at the read pointer when valid, and 0 when empty.
  - Driven from registered state plus combinational read of storage, with no combinational path from in_* or grant.
- wait_cycles:
  - Is 0 when empty.
  - At each edge where the head is valid and not granted, increments by 1, saturating at 2^COUNTER_WIDTH-1 with no wrap.
  - At an edge with a grant, clears to 0. The next head starts counting from 0.
- count ranges 0..DEPTH and never over- or underflows.

Test Plan:
1. Reset, then one push of addr=3, value=0xA5 with no grant -> in the next cycle req=13'h13A5 and count=1. wait_cycles reads 1, 2, 3 on successive cycles.
2. Push 4 entries (addr 0..3, value 0x10..0x13) with no grant -> count=4 and in_ready=0. A 5th in_valid is not accepted. Then grant 4 cycles -> req shows 13'h1010, 13'h1111, 13'h1212, 13'h1313 in order, then 0, with count=0.
3. With 2 entries held, push and grant in the same cycle for 6 cycles -> count stays 2, in-order data is preserved, and pointers wrap correctly past index 3.
4. Grant while empty -> count=0, req=0, pointers unchanged. A subsequent push appears normally.
5. Hold the head ungranted for 300 cycles -> wait_cycles saturates at 8'hFF. Grant -> 0 on the next cycle.
6. Assert reset mid-stream with count=3 -> count=0, req=0 and in_ready=1 immediately (asynchronously). After release, a push shows the new data at the head.
